// File: rtl/sdram_arbiter.sv
// Round-robin arbiter sharing one SDRAM controller between NUM_PORTS requesters.
// One transaction outstanding at a time; completions and read beats go back to the owner.
module sdram_arbiter #(
    parameter int NUM_PORTS          = 2,
    parameter int USER_ADDRESS_WIDTH = 24,
    parameter int DATA_WIDTH         = 16,
    parameter int QUIESCE_CYCLES     = 32
) (
    input  logic                                     clk,
    input  logic                                     reset_n,
    input  logic [NUM_PORTS-1:0]                     req_valid,
    input  logic [NUM_PORTS-1:0]                     req_write,
    input  logic [NUM_PORTS*USER_ADDRESS_WIDTH-1:0]  req_address,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]          req_write_data,
    output logic [NUM_PORTS-1:0]                     req_ready,
    output logic [NUM_PORTS-1:0]                     resp_write_done,
    output logic [NUM_PORTS-1:0]                     resp_read_valid,
    output logic [DATA_WIDTH-1:0]                    resp_read_data,
    output logic [1:0]                               ctrl_command,
    output logic [USER_ADDRESS_WIDTH-1:0]            ctrl_data_address,
    output logic [DATA_WIDTH-1:0]                    ctrl_data_write,
    input  logic [DATA_WIDTH-1:0]                    ctrl_data_read,
    input  logic                                     ctrl_data_read_valid,
    input  logic                                     ctrl_data_write_done
);

    localparam int GW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int QW = (QUIESCE_CYCLES > 1) ? $clog2(QUIESCE_CYCLES) : 1;
    localparam logic [QW-1:0] QUIESCE_LOAD = QW'(QUIESCE_CYCLES - 1);
    localparam logic [GW-1:0] LAST_PORT    = GW'(NUM_PORTS - 1);

    typedef enum logic [2:0] {
        ST_QUIESCE = 3'd0,
        ST_IDLE    = 3'd1,
        ST_WRITE   = 3'd2,
        ST_READ    = 3'd3,
        ST_DRAIN   = 3'd4
    } state_t;

    state_t                        state_r;
    logic [QW-1:0]                 quiesce_cnt_r;
    logic [GW-1:0]                 last_grant_r;
    logic [GW-1:0]                 grant_r;
    logic [NUM_PORTS-1:0]          resp_write_done_r;
    logic [NUM_PORTS-1:0]          resp_read_valid_r;
    logic [DATA_WIDTH-1:0]         resp_read_data_r;
    logic [1:0]                    ctrl_command_r;
    logic [USER_ADDRESS_WIDTH-1:0] ctrl_data_address_r;
    logic [DATA_WIDTH-1:0]         ctrl_data_write_r;

    logic                          grant_found_s;
    logic [GW-1:0]                 grant_idx_s;
    logic [GW-1:0]                 cand_s;
    logic [NUM_PORTS-1:0]          req_ready_s;

    // Round-robin search starting just after the previous winner.
    always_comb begin
        grant_found_s = 1'b0;
        grant_idx_s   = '0;
        cand_s        = '0;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            cand_s = GW'((int'(last_grant_r) + i) % NUM_PORTS);
            if (!grant_found_s && req_valid[cand_s]) begin
                grant_found_s = 1'b1;
                grant_idx_s   = cand_s;
            end else begin
                grant_found_s = grant_found_s;
            end
        end
    end

    // Accept handshake: ready is offered only while idle, to the search winner.
    always_comb begin
        req_ready_s = '0;
        if ((state_r == ST_IDLE) && grant_found_s) begin
            req_ready_s[grant_idx_s] = 1'b1;
        end else begin
            req_ready_s = '0;
        end
    end

    // Transaction sequencer with registered controller command and responses.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r             <= ST_QUIESCE;
            quiesce_cnt_r       <= QUIESCE_LOAD;
            last_grant_r        <= LAST_PORT;
            grant_r             <= '0;
            resp_write_done_r   <= '0;
            resp_read_valid_r   <= '0;
            resp_read_data_r    <= '0;
            ctrl_command_r      <= 2'd0;
            ctrl_data_address_r <= '0;
            ctrl_data_write_r   <= '0;
        end else begin
            resp_write_done_r <= '0;
            resp_read_valid_r <= '0;
            case (state_r)
                ST_QUIESCE: begin
                    ctrl_command_r <= 2'd0;
                    if (quiesce_cnt_r == '0) begin
                        state_r <= ST_IDLE;
                    end else begin
                        quiesce_cnt_r <= quiesce_cnt_r - 1'b1;
                    end
                end
                ST_IDLE: begin
                    // Stale controller traffic seen here is deliberately dropped.
                    if (grant_found_s) begin
                        grant_r             <= grant_idx_s;
                        last_grant_r        <= grant_idx_s;
                        ctrl_data_address_r <= req_address[grant_idx_s*USER_ADDRESS_WIDTH +: USER_ADDRESS_WIDTH];
                        ctrl_data_write_r   <= req_write_data[grant_idx_s*DATA_WIDTH +: DATA_WIDTH];
                        if (req_write[grant_idx_s]) begin
                            state_r        <= ST_WRITE;
                            ctrl_command_r <= 2'd1;
                        end else begin
                            state_r        <= ST_READ;
                            ctrl_command_r <= 2'd2;
                        end
                    end
                end
                ST_WRITE: begin
                    if (ctrl_data_write_done) begin
                        ctrl_command_r             <= 2'd0;
                        resp_write_done_r[grant_r] <= 1'b1;
                        state_r                    <= ST_IDLE;
                    end
                end
                ST_READ: begin
                    resp_read_valid_r[grant_r] <= ctrl_data_read_valid;
                    resp_read_data_r           <= ctrl_data_read;
                    // Drop the command on the first beat so the read is never reissued.
                    if (ctrl_data_read_valid) begin
                        ctrl_command_r <= 2'd0;
                        state_r        <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    resp_read_valid_r[grant_r] <= ctrl_data_read_valid;
                    resp_read_data_r           <= ctrl_data_read;
                    if (!ctrl_data_read_valid) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r        <= ST_QUIESCE;
                    quiesce_cnt_r  <= QUIESCE_LOAD;
                    ctrl_command_r <= 2'd0;
                end
            endcase
        end
    end

    assign req_ready         = req_ready_s;
    assign resp_write_done   = resp_write_done_r;
    assign resp_read_valid   = resp_read_valid_r;
    assign resp_read_data    = resp_read_data_r;
    assign ctrl_command      = ctrl_command_r;
    assign ctrl_data_address = ctrl_data_address_r;
    assign ctrl_data_write   = ctrl_data_write_r;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed self-checking bench for sdram_arbiter; the bench plays both requesters and the controller.
module tb_sdram_arbiter;

    localparam int NP = 2;
    localparam int AW = 24;
    localparam int DW = 16;
    localparam int Q  = 8;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [NP-1:0]   req_valid;
    logic [NP-1:0]   req_write;
    logic [NP*AW-1:0] req_address;
    logic [NP*DW-1:0] req_write_data;
    logic [NP-1:0]   req_ready;
    logic [NP-1:0]   resp_write_done;
    logic [NP-1:0]   resp_read_valid;
    logic [DW-1:0]   resp_read_data;
    logic [1:0]      ctrl_command;
    logic [AW-1:0]   ctrl_data_address;
    logic [DW-1:0]   ctrl_data_write;
    logic [DW-1:0]   ctrl_data_read;
    logic            ctrl_data_read_valid;
    logic            ctrl_data_write_done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] beats_a [0:3] = '{16'h0011, 16'h0022, 16'h0033, 16'h0044};
    logic [DW-1:0] beats_b [0:3] = '{16'h0055, 16'h0066, 16'h0077, 16'h0088};

    sdram_arbiter #(
        .NUM_PORTS(NP), .USER_ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .QUIESCE_CYCLES(Q)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_write(req_write),
        .req_address(req_address), .req_write_data(req_write_data),
        .req_ready(req_ready), .resp_write_done(resp_write_done),
        .resp_read_valid(resp_read_valid), .resp_read_data(resp_read_data),
        .ctrl_command(ctrl_command), .ctrl_data_address(ctrl_data_address),
        .ctrl_data_write(ctrl_data_write), .ctrl_data_read(ctrl_data_read),
        .ctrl_data_read_valid(ctrl_data_read_valid), .ctrl_data_write_done(ctrl_data_write_done)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        step; step;
        #1;
        if (req_ready !== 2'b00 || resp_write_done !== 2'b00 || resp_read_valid !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_flags: ready=%b wdone=%b rvalid=%b required 00/00/00", req_ready, resp_write_done, resp_read_valid);
        end
        n_checks++;
        if (ctrl_command !== 2'd0 || ctrl_data_address !== 24'h0 || ctrl_data_write !== 16'h0 || resp_read_data !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_ctrl: cmd=%0d addr=%h wdata=%h rdata=%h required all 0", ctrl_command, ctrl_data_address, ctrl_data_write, resp_read_data);
        end
        n_checks++;
    endtask

    task automatic test_quiesce_write;
        int early;
        int stable_err;
        int after_err;
        early = 0; stable_err = 0; after_err = 0;
        step;
        reset_n = 1'b1;
        req_valid = 2'b01; req_write = 2'b01;
        req_address = {24'hFFFFFF, 24'h000123};
        req_write_data = {16'h5A5A, 16'hBEEF};
        for (int k = 0; k < Q; k++) begin
            #1;
            if (req_ready !== 2'b00 || ctrl_command !== 2'd0) early++;
            step;
        end
        if (early !== 0) begin
            n_fail++;
            $display("FAIL quiesce_early: %0d early ready/command cycles, required 0", early);
        end
        n_checks++;
        #1;
        if (req_ready !== 2'b01) begin
            n_fail++;
            $display("FAIL quiesce_accept: req_ready=%b required 01", req_ready);
        end
        n_checks++;
        step;
        req_valid = 2'b00;
        #1;
        if (ctrl_command !== 2'd1 || ctrl_data_address !== 24'h000123 || ctrl_data_write !== 16'hBEEF || req_ready !== 2'b00) begin
            n_fail++;
            $display("FAIL write_issue: cmd=%0d addr=%h data=%h ready=%b required 1/000123/beef/00", ctrl_command, ctrl_data_address, ctrl_data_write, req_ready);
        end
        n_checks++;
        for (int k = 0; k < 3; k++) begin
            step; #1;
            if (ctrl_command !== 2'd1 || ctrl_data_address !== 24'h000123 || ctrl_data_write !== 16'hBEEF) stable_err++;
        end
        if (stable_err !== 0) begin
            n_fail++;
            $display("FAIL write_stable: %0d unstable cycles, required 0", stable_err);
        end
        n_checks++;
        step;
        ctrl_data_write_done = 1'b1;
        #1;
        if (resp_write_done !== 2'b00 || ctrl_command !== 2'd1) begin
            n_fail++;
            $display("FAIL write_done_cycle: wdone=%b cmd=%0d required 00/1", resp_write_done, ctrl_command);
        end
        n_checks++;
        step;
        ctrl_data_write_done = 1'b0;
        #1;
        if (resp_write_done !== 2'b01 || ctrl_command !== 2'd0) begin
            n_fail++;
            $display("FAIL write_resp: wdone=%b cmd=%0d required 01/0", resp_write_done, ctrl_command);
        end
        n_checks++;
        for (int k = 0; k < 5; k++) begin
            step; #1;
            if (ctrl_command !== 2'd0 || resp_write_done !== 2'b00) after_err++;
        end
        if (after_err !== 0) begin
            n_fail++;
            $display("FAIL write_no_reissue: %0d bad cycles, required 0", after_err);
        end
        n_checks++;
    endtask

    task automatic test_read;
        int hi_count;
        hi_count = 0;
        step;
        req_valid = 2'b10; req_write = 2'b00;
        req_address = {24'h000456, 24'h000000};
        #1;
        if (req_ready !== 2'b10) begin
            n_fail++;
            $display("FAIL read_accept: req_ready=%b required 10", req_ready);
        end
        n_checks++;
        step;
        req_valid = 2'b00;
        #1;
        if (ctrl_command !== 2'd2 || ctrl_data_address !== 24'h000456) begin
            n_fail++;
            $display("FAIL read_issue: cmd=%0d addr=%h required 2/000456", ctrl_command, ctrl_data_address);
        end
        n_checks++;
        step; step;
        for (int b = 0; b < 4; b++) begin
            step;
            ctrl_data_read_valid = 1'b1;
            ctrl_data_read = beats_a[b];
            #1;
            if (resp_read_valid == 2'b10) hi_count++;
            if (b == 0) begin
                if (resp_read_valid !== 2'b00 || ctrl_command !== 2'd2) begin
                    n_fail++;
                    $display("FAIL read_first_beat: rvalid=%b cmd=%0d required 00/2", resp_read_valid, ctrl_command);
                end
            end else begin
                if (resp_read_valid !== 2'b10 || resp_read_data !== beats_a[b-1] || ctrl_command !== 2'd0) begin
                    n_fail++;
                    $display("FAIL read_beat%0d: rvalid=%b data=%h cmd=%0d required 10/%h/0", b, resp_read_valid, resp_read_data, ctrl_command, beats_a[b-1]);
                end
            end
            n_checks++;
        end
        step;
        ctrl_data_read_valid = 1'b0;
        ctrl_data_read = 16'h0000;
        req_valid = 2'b01; req_write = 2'b01;
        req_address = {24'h000000, 24'h000321};
        req_write_data = {16'h0000, 16'h1234};
        #1;
        if (resp_read_valid == 2'b10) hi_count++;
        if (resp_read_valid !== 2'b10 || resp_read_data !== 16'h0044 || req_ready !== 2'b00) begin
            n_fail++;
            $display("FAIL read_last_beat: rvalid=%b data=%h ready=%b required 10/0044/00", resp_read_valid, resp_read_data, req_ready);
        end
        n_checks++;
        step;
        #1;
        if (resp_read_valid !== 2'b00 || req_ready !== 2'b01) begin
            n_fail++;
            $display("FAIL read_to_idle: rvalid=%b ready=%b required 00/01", resp_read_valid, req_ready);
        end
        n_checks++;
        if (hi_count !== 4) begin
            n_fail++;
            $display("FAIL read_beat_count: %0d beats forwarded, required 4", hi_count);
        end
        n_checks++;
        step;
        req_valid = 2'b00;
        #1;
        if (ctrl_command !== 2'd1 || ctrl_data_address !== 24'h000321 || ctrl_data_write !== 16'h1234) begin
            n_fail++;
            $display("FAIL b2b_write_issue: cmd=%0d addr=%h data=%h required 1/000321/1234", ctrl_command, ctrl_data_address, ctrl_data_write);
        end
        n_checks++;
        ctrl_data_write_done = 1'b1;
        step;
        ctrl_data_write_done = 1'b0;
        #1;
        if (resp_write_done !== 2'b01) begin
            n_fail++;
            $display("FAIL b2b_write_resp: wdone=%b required 01", resp_write_done);
        end
        n_checks++;
    endtask

    task automatic test_stale;
        ctrl_data_read_valid = 1'b1;
        ctrl_data_write_done = 1'b1;
        ctrl_data_read = 16'hDEAD;
        step;
        ctrl_data_read_valid = 1'b0;
        ctrl_data_write_done = 1'b0;
        #1;
        if (resp_read_valid !== 2'b00 || resp_write_done !== 2'b00 || ctrl_command !== 2'd0) begin
            n_fail++;
            $display("FAIL stale_ignored: rvalid=%b wdone=%b cmd=%0d required 00/00/0", resp_read_valid, resp_write_done, ctrl_command);
        end
        n_checks++;
    endtask

    task automatic test_cancel;
        int bad;
        bad = 0;
        step;
        req_valid = 2'b01; req_write = 2'b01;
        req_address = {24'h000BBB, 24'h000AAA};
        #1;
        if (req_ready !== 2'b01) begin
            n_fail++;
            $display("FAIL cancel_setup_accept: req_ready=%b required 01", req_ready);
        end
        n_checks++;
        step;
        req_valid = 2'b10; req_write = 2'b10;
        #1;
        if (req_ready !== 2'b00) bad++;
        step; #1;
        if (req_ready !== 2'b00) bad++;
        step;
        req_valid = 2'b00;
        ctrl_data_write_done = 1'b1;
        step;
        ctrl_data_write_done = 1'b0;
        #1;
        if (resp_write_done !== 2'b01) begin
            n_fail++;
            $display("FAIL cancel_owner_done: wdone=%b required 01", resp_write_done);
        end
        n_checks++;
        for (int k = 0; k < 5; k++) begin
            step; #1;
            if (req_ready !== 2'b00 || ctrl_command !== 2'd0) bad++;
        end
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL cancel_no_grant: %0d bad cycles, required 0", bad);
        end
        n_checks++;
    endtask

    task automatic test_round_robin;
        int waited;
        logic [1:0] exp;
        logic [AW-1:0] exp_addr;
        step;
        reset_n = 1'b0;
        req_valid = 2'b00;
        step;
        reset_n = 1'b1;
        for (int k = 0; k < Q; k++) step;
        req_valid = 2'b11; req_write = 2'b11;
        req_address = {24'h0000B1, 24'h0000A0};
        for (int t = 0; t < 6; t++) begin
            exp = (t % 2 == 0) ? 2'b01 : 2'b10;
            exp_addr = (t % 2 == 0) ? 24'h0000A0 : 24'h0000B1;
            waited = 0;
            #1;
            while (req_ready === 2'b00 && waited < 20) begin
                step; #1;
                waited++;
            end
            if (req_ready !== exp || waited !== 0) begin
                n_fail++;
                $display("FAIL rr_grant%0d: req_ready=%b after %0d waits, required %b after 0", t, req_ready, waited, exp);
            end
            n_checks++;
            step; #1;
            if (ctrl_data_address !== exp_addr || ctrl_command !== 2'd1) begin
                n_fail++;
                $display("FAIL rr_addr%0d: addr=%h cmd=%0d required %h/1", t, ctrl_data_address, ctrl_command, exp_addr);
            end
            n_checks++;
            ctrl_data_write_done = 1'b1;
            step;
            ctrl_data_write_done = 1'b0;
        end
        req_valid = 2'b00;
    endtask

    task automatic test_reset_in_drain;
        int waited;
        step;
        req_valid = 2'b01; req_write = 2'b00;
        req_address = {24'h000000, 24'h000777};
        #1;
        if (req_ready !== 2'b01) begin
            n_fail++;
            $display("FAIL rst_read_accept: req_ready=%b required 01", req_ready);
        end
        n_checks++;
        step;
        req_valid = 2'b00;
        step;
        ctrl_data_read_valid = 1'b1; ctrl_data_read = 16'h00AA;
        step;
        ctrl_data_read = 16'h00BB;
        reset_n = 1'b0;
        #1;
        if (resp_read_valid !== 2'b01 || resp_read_data !== 16'h00AA) begin
            n_fail++;
            $display("FAIL rst_pre_beat: rvalid=%b data=%h required 01/00aa", resp_read_valid, resp_read_data);
        end
        n_checks++;
        step;
        reset_n = 1'b1;
        ctrl_data_read = 16'h00CC;
        #1;
        if (resp_read_valid !== 2'b00 || ctrl_command !== 2'd0) begin
            n_fail++;
            $display("FAIL rst_drop: rvalid=%b cmd=%0d required 00/0", resp_read_valid, ctrl_command);
        end
        n_checks++;
        step;
        ctrl_data_read = 16'h00DD;
        #1;
        if (resp_read_valid !== 2'b00) begin
            n_fail++;
            $display("FAIL rst_discard: rvalid=%b required 00", resp_read_valid);
        end
        n_checks++;
        step;
        ctrl_data_read_valid = 1'b0;
        req_valid = 2'b01; req_write = 2'b00;
        req_address = {24'h000000, 24'h000888};
        waited = 0;
        #1;
        while (req_ready === 2'b00 && waited < 40) begin
            step; #1;
            waited++;
        end
        if (req_ready !== 2'b01 || waited !== Q - 2) begin
            n_fail++;
            $display("FAIL rst_requiesce: ready=%b after %0d waits, required 01 after %0d", req_ready, waited, Q - 2);
        end
        n_checks++;
        step;
        req_valid = 2'b00;
        #1;
        if (ctrl_command !== 2'd2 || ctrl_data_address !== 24'h000888) begin
            n_fail++;
            $display("FAIL rst_read_issue: cmd=%0d addr=%h required 2/000888", ctrl_command, ctrl_data_address);
        end
        n_checks++;
        for (int b = 0; b < 5; b++) begin
            step;
            ctrl_data_read_valid = (b < 4);
            ctrl_data_read = (b < 4) ? beats_b[b] : 16'h0000;
            #1;
            if (b > 0) begin
                if (resp_read_valid !== 2'b01 || resp_read_data !== beats_b[b-1]) begin
                    n_fail++;
                    $display("FAIL rst_read_beat%0d: rvalid=%b data=%h required 01/%h", b, resp_read_valid, resp_read_data, beats_b[b-1]);
                end
                n_checks++;
            end
        end
        step; #1;
        if (resp_read_valid !== 2'b00) begin
            n_fail++;
            $display("FAIL rst_read_end: rvalid=%b required 00", resp_read_valid);
        end
        n_checks++;
    endtask

    initial begin
        reset_n = 1'b0;
        req_valid = '0; req_write = '0; req_address = '0; req_write_data = '0;
        ctrl_data_read = '0; ctrl_data_read_valid = 1'b0; ctrl_data_write_done = 1'b0;
        test_reset;
        test_quiesce_write;
        test_read;
        test_stale;
        test_cancel;
        test_round_robin;
        test_reset_in_drain;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
